// File: rtl/mips_imem_loader.sv
// mips_imem_loader
//   Packs an incoming byte stream into 32-bit instruction words and writes
//   them to the instruction memory starting at word 0. The mips core is held
//   in reset until the final word of the program has been written.
//
//   Parameters:
//     ADDR_W     imem word-address width
//     MAX_WORDS  imem depth in words (<= 2**ADDR_W)
//     BIG_ENDIAN 1: first byte lands in wdata[31:24]; 0: first byte in wdata[7:0]
//
//   Ports:
//     clk, rst         clock; asynchronous active-high reset
//     in_valid/in_data/in_last/in_ready   byte stream (valid/ready handshake)
//     reload           restart a load from word 0 when in DONE or ERR
//     imem_we/imem_addr/imem_wdata        imem write port (one-cycle strobe)
//     core_rst         reset to the mips core, low only in DONE
//     load_done        program fully written
//     err_overflow     stream ran past MAX_WORDS (sticky until reload/rst)
//     word_count       words written during the current load
module mips_imem_loader #(
  parameter int ADDR_W     = 8,
  parameter int MAX_WORDS  = 256,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {LOAD, WRITE, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);

  state_t            state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_ptr, word_ptr_n;
  logic [31:0]       buffer, buffer_n;
  logic              last_q, last_n;
  logic [ADDR_W:0]   word_count_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [31:0]       imem_wdata_n;
  logic              in_ready_n, imem_we_n, core_rst_n, load_done_n, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      byte_cnt <= '0;
      word_ptr <= '0;
      buffer   <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      word_ptr <= word_ptr_n;
      buffer   <= buffer_n;
      last_q   <= last_n;
    end
  end

  // Registered outputs are driven from the next state, so each flag is
  // valid in the very first cycle of the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst     <= 1'b1;
      load_done    <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
    end else begin
      in_ready     <= in_ready_n;
      imem_we      <= imem_we_n;
      imem_addr    <= imem_addr_n;
      imem_wdata   <= imem_wdata_n;
      core_rst     <= core_rst_n;
      load_done    <= load_done_n;
      err_overflow <= err_n;
      word_count   <= word_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    word_ptr_n   = word_ptr;
    buffer_n     = buffer;
    last_n       = last_q;
    word_count_n = word_count;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    lane         = BIG_ENDIAN ? ~byte_cnt : byte_cnt;

    unique case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          unique case (lane)
            2'd0: buffer_n[7:0]   = in_data;
            2'd1: buffer_n[15:8]  = in_data;
            2'd2: buffer_n[23:16] = in_data;
            2'd3: buffer_n[31:24] = in_data;
          endcase
          byte_cnt_n = byte_cnt + 2'd1;
          if (in_last) last_n = 1'b1;
          if (byte_cnt == 2'd3 || in_last) begin
            state_n      = WRITE;
            imem_addr_n  = word_ptr;
            imem_wdata_n = buffer_n;
          end
        end
      end
      WRITE: begin
        word_ptr_n   = word_ptr + PTR_ONE;
        word_count_n = word_count + WC_ONE;
        byte_cnt_n   = '0;
        buffer_n     = '0;
        last_n       = 1'b0;
        if (last_q)                  state_n = DONE;
        else if (word_ptr == LAST_PTR) state_n = ERR;
        else                         state_n = LOAD;
      end
      DONE, ERR: begin
        if (reload) begin
          state_n      = LOAD;
          word_ptr_n   = '0;
          word_count_n = '0;
          byte_cnt_n   = '0;
          buffer_n     = '0;
          last_n       = 1'b0;
        end
      end
      default: state_n = LOAD;
    endcase

    in_ready_n  = (state_n == LOAD);
    imem_we_n   = (state_n == WRITE);
    core_rst_n  = (state_n != DONE);
    load_done_n = (state_n == DONE);
    err_n       = (state_n == ERR);
  end

endmodule

// File: tb/tb_mips_imem_loader.sv
module tb_mips_imem_loader;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_last, reload;
  logic [7:0] in_data;

  // b_: big-endian default, l_: little-endian, s_: MAX_WORDS=4
  logic       b_ready, b_we, b_crst, b_done, b_err;
  logic [7:0] b_addr;
  logic [31:0] b_wdata;
  logic [8:0] b_wc;
  logic       l_ready, l_we, l_crst, l_done, l_err;
  logic [7:0] l_addr;
  logic [31:0] l_wdata;
  logic [8:0] l_wc;
  logic       s_ready, s_we, s_crst, s_done, s_err;
  logic [7:0] s_addr;
  logic [31:0] s_wdata;
  logic [8:0] s_wc;

  int total = 0;
  int bad = 0;
  int nb, nl, ns;
  int sel;
  logic [31:0] mb [16];
  logic [31:0] ml [16];
  logic [31:0] ms [16];
  logic [7:0] t1 [8];

  always #5 clk = ~clk;

  mips_imem_loader #(.ADDR_W(8), .MAX_WORDS(256), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_ready), .reload(reload), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .core_rst(b_crst), .load_done(b_done),
    .err_overflow(b_err), .word_count(b_wc));

  mips_imem_loader #(.ADDR_W(8), .MAX_WORDS(256), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(l_ready), .reload(reload), .imem_we(l_we), .imem_addr(l_addr),
    .imem_wdata(l_wdata), .core_rst(l_crst), .load_done(l_done),
    .err_overflow(l_err), .word_count(l_wc));

  mips_imem_loader #(.ADDR_W(8), .MAX_WORDS(4), .BIG_ENDIAN(1'b1)) u_sm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(s_ready), .reload(reload), .imem_we(s_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .core_rst(s_crst), .load_done(s_done),
    .err_overflow(s_err), .word_count(s_wc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge and log any imem writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (b_we === 1'b1) begin
      check("b_wr_addr", {24'h0, b_addr}, nb);
      check("b_wr_ready_low", {31'h0, b_ready}, 0);
      if (nb < 16) mb[nb] = b_wdata;
      nb++;
    end
    if (l_we === 1'b1) begin
      check("l_wr_addr", {24'h0, l_addr}, nl);
      if (nl < 16) ml[nl] = l_wdata;
      nl++;
    end
    if (s_we === 1'b1) begin
      check("s_wr_addr", {24'h0, s_addr}, ns);
      check("s_wr_ready_low", {31'h0, s_ready}, 0);
      if (ns < 16) ms[ns] = s_wdata;
      ns++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input bit gap);
    logic rdy;
    logic acc;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      rdy = (sel == 2) ? s_ready : b_ready;
      tick();
      acc = rdy;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("byte_accepted", {31'h0, acc}, 1);
  endtask

  task automatic send_t1(input bit gap);
    for (int i = 0; i < 8; i++) send(t1[i], i == 7, gap);
  endtask

  task automatic clr();
    nb = 0; nl = 0; ns = 0;
  endtask

  task automatic do_reload();
    clr();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    t1[0] = 8'h20; t1[1] = 8'h08; t1[2] = 8'h00; t1[3] = 8'h05;
    t1[4] = 8'h20; t1[5] = 8'h09; t1[6] = 8'h00; t1[7] = 8'h07;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reload = 1'b0;
    sel = 0;
    clr();

    // reset state
    tick(); tick();
    check("rst_ready", {31'h0, b_ready}, 0);
    check("rst_core_rst", {31'h0, b_crst}, 1);
    check("rst_done", {31'h0, b_done}, 0);
    check("rst_err", {31'h0, b_err}, 0);
    check("rst_wc", {23'h0, b_wc}, 0);
    rst = 1'b0;
    tick();
    check("rel_ready", {31'h0, b_ready}, 1);
    check("rel_core_rst", {31'h0, b_crst}, 1);

    // test 1: two-word program
    send_t1(1'b0);
    tick();
    check("t1_nwr", nb, 2);
    check("t1_w0", mb[0], 32'h20080005);
    check("t1_w1", mb[1], 32'h20090007);
    check("t1_le_w0", ml[0], 32'h05000820);
    check("t1_core_rst", {31'h0, b_crst}, 0);
    check("t1_done", {31'h0, b_done}, 1);
    check("t1_wc", {23'h0, b_wc}, 2);
    check("t1_ready", {31'h0, b_ready}, 0);
    check("t1_we_idle", {31'h0, b_we}, 0);
    tick();
    check("t1_done_hold", {31'h0, b_done}, 1);

    // test 5: reload from DONE
    do_reload();
    check("t5_core_rst", {31'h0, b_crst}, 1);
    check("t5_done_clr", {31'h0, b_done}, 0);
    check("t5_wc_clr", {23'h0, b_wc}, 0);
    check("t5_ready", {31'h0, b_ready}, 1);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h0C, 1'b1, 1'b0);
    tick();
    check("t5_nwr", nb, 1);
    check("t5_w0", mb[0], 32'h0000000C);
    check("t5_done", {31'h0, b_done}, 1);
    check("t5_wc", {23'h0, b_wc}, 1);

    // test 2: short last word, both endians
    do_reload();
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hBB, 1'b1, 1'b0);
    tick();
    check("t2_be_w0", mb[0], 32'hAABBBB00);
    check("t2_le_w0", ml[0], 32'h00BBBBAA);
    check("t2_le_nwr", nl, 1);
    check("t2_le_done", {31'h0, l_done}, 1);
    check("t2_wc", {23'h0, b_wc}, 1);

    // test 4: random valid gaps
    do_reload();
    send_t1(1'b1);
    tick();
    check("t4_nwr", nb, 2);
    check("t4_w0", mb[0], 32'h20080005);
    check("t4_w1", mb[1], 32'h20090007);
    check("t4_done", {31'h0, b_done}, 1);
    check("t4_wc", {23'h0, b_wc}, 2);

    // test 6: async reset mid-load, then a clean reload
    do_reload();
    for (int i = 0; i < 6; i++) send(t1[i], 1'b0, 1'b0);
    check("t6_pre_wc", {23'h0, b_wc}, 1);
    check("t6_pre_wdata", b_wdata, 32'h20080005);
    #1 rst = 1'b1;
    #1;
    check("t6_ready", {31'h0, b_ready}, 0);
    check("t6_we", {31'h0, b_we}, 0);
    check("t6_addr", {24'h0, b_addr}, 0);
    check("t6_wdata", b_wdata, 0);
    check("t6_core_rst", {31'h0, b_crst}, 1);
    check("t6_done", {31'h0, b_done}, 0);
    check("t6_wc", {23'h0, b_wc}, 0);
    tick();
    rst = 1'b0;
    clr();
    tick();
    send_t1(1'b0);
    tick();
    check("t6_nwr", nb, 2);
    check("t6_w0", mb[0], 32'h20080005);
    check("t6_w1", mb[1], 32'h20090007);
    check("t6_done2", {31'h0, b_done}, 1);

    // test 3: overflow with MAX_WORDS=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    tick();
    sel = 2;
    for (int i = 0; i < 16; i++) send(8'(i + 1), 1'b0, 1'b0);
    tick();
    check("t3_nwr", ns, 4);
    check("t3_w0", ms[0], 32'h01020304);
    check("t3_w3", ms[3], 32'h0D0E0F10);
    check("t3_err", {31'h0, s_err}, 1);
    check("t3_core_rst", {31'h0, s_crst}, 1);
    check("t3_ready", {31'h0, s_ready}, 0);
    check("t3_done", {31'h0, s_done}, 0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (8) tick();
    in_valid = 1'b0;
    check("t3_ready_hold", {31'h0, s_ready}, 0);
    check("t3_nwr_hold", ns, 4);
    check("t3_err_sticky", {31'h0, s_err}, 1);
    check("t3_wc", {23'h0, s_wc}, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
